// File: rtl/pll_lock_pkg.sv
// Shared types and width helpers for the PLL lock monitor.
// Contents:
//   lock_state_t : FSM encoding (IDLE=0, ACQ=1, LOCKED=2; 3 is illegal)
//   STATE_W      : width of the exported state field
//   cnt_w()      : width of a counter that must hold values 0..max_val
package pll_lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int STATE_W = 2;

    // Width needed to represent 0..max_val. The result is never below 1 bit,
    // so degenerate parameters still give a legal vector.
    function automatic int cnt_w(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/lock_err_window.sv
// Windowed error budget used while the PLL is locked.
// wcnt walks 0..WIN-1 and wraps; ecnt counts error cycles in the current
// window. trip is asserted combinationally in the cycle that carries the
// UNLOCK_ERRS-th error of a window, so the owner can react on that same edge.
// Ports:
//   clk   in  reference clock
//   rst_n in  synchronous active-low reset
//   run   in  1 while supervising; 0 holds both counters at 0
//   err   in  error indication for this cycle
//   trip  out error budget exhausted in the current window
import pll_lock_pkg::*;

module lock_err_window #(
    parameter int WIN         = 256,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic err,
    output logic trip
);

    localparam int WCNT_W = cnt_w(WIN - 1);
    localparam int ECNT_W = cnt_w(UNLOCK_ERRS);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [ECNT_W-1:0] ECNT_TRIP = ECNT_W'(UNLOCK_ERRS - 1);
    localparam logic [ECNT_W-1:0] ECNT_MAX  = ECNT_W'(UNLOCK_ERRS);
    localparam logic [ECNT_W-1:0] ECNT_ONE  = ECNT_W'(1);

    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_nxt_s;
    logic [ECNT_W-1:0] ecnt_r;
    logic [ECNT_W-1:0] ecnt_nxt_s;

    // Trip detection and next values for the window and error counters.
    always_comb begin
        wcnt_nxt_s = '0;
        ecnt_nxt_s = '0;
        trip       = 1'b0;
        if (run) begin
            // An error in the last cycle of a window still belongs to it:
            // the trip test happens before the wrap clears ecnt.
            trip = err && (ecnt_r == ECNT_TRIP);
            if (wcnt_r == WCNT_LAST) begin
                wcnt_nxt_s = '0;
                ecnt_nxt_s = '0;
            end else begin
                wcnt_nxt_s = wcnt_r + WCNT_ONE;
                if (err && (ecnt_r != ECNT_MAX)) begin
                    ecnt_nxt_s = ecnt_r + ECNT_ONE;
                end else begin
                    ecnt_nxt_s = ecnt_r;
                end
            end
        end else begin
            wcnt_nxt_s = '0;
            ecnt_nxt_s = '0;
        end
    end

    // Window and error counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_r <= '0;
            ecnt_r <= '0;
        end else begin
            wcnt_r <= wcnt_nxt_s;
            ecnt_r <= ecnt_nxt_s;
        end
    end

endmodule

// File: rtl/lock_monitor.sv
// PLL lock detector: acquires lock after LOCK_CNT consecutive quiet PFD
// cycles, then supervises lock with a windowed error budget and reports
// loss of lock with a one-cycle pulse and a sticky flag.
// Ports:
//   clk, rst_n  reference clock, synchronous active-low reset
//   en          monitor enable; 0 returns to IDLE
//   up, dn      PFD UP / DN
//   clr_sticky  clears lol_sticky (a same-cycle LOL event wins)
//   locked      lock status
//   state       current FSM state (pll_lock_pkg encoding)
//   lol_pulse   one-cycle pulse per loss-of-lock event
//   lol_sticky  set on loss of lock, held until clr_sticky
//   lock_cnt    saturating count of lock acquisitions
// All outputs are registered.
import pll_lock_pkg::*;

module lock_monitor #(
    parameter int LOCK_CNT      = 1024,
    parameter int WIN           = 256,
    parameter int UNLOCK_ERRS   = 4,
    parameter int BOTH_IS_QUIET = 1,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up,
    input  logic               dn,
    input  logic               clr_sticky,
    output logic               locked,
    output logic [STATE_W-1:0] state,
    output logic               lol_pulse,
    output logic               lol_sticky,
    output logic [CNT_W-1:0]   lock_cnt
);

    localparam int QCNT_W = cnt_w(LOCK_CNT);

    localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(LOCK_CNT - 1);
    localparam logic [QCNT_W-1:0] QCNT_ONE  = QCNT_W'(1);
    localparam logic [CNT_W-1:0]  LCNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LCNT_ONE  = CNT_W'(1);

    lock_state_t       state_r;
    lock_state_t       state_nxt_s;
    logic [QCNT_W-1:0] qcnt_r;
    logic [QCNT_W-1:0] qcnt_nxt_s;
    logic [CNT_W-1:0]  lock_cnt_r;
    logic [CNT_W-1:0]  lock_cnt_nxt_s;
    logic              locked_r;
    logic              lol_pulse_r;
    logic              lol_sticky_r;
    logic              lol_sticky_nxt_s;
    logic              err_s;
    logic              run_s;
    logic              trip_s;
    logic              lock_evt_s;
    logic              lol_evt_s;

    // PFD error classification; up&&dn is a single event either way.
    always_comb begin
        err_s = 1'b0;
        if (BOTH_IS_QUIET != 0) begin
            err_s = up ^ dn;
        end else begin
            err_s = up | dn;
        end
    end

    // The window only runs while locked and still enabled, so it is always
    // back at zero when lock is (re)acquired.
    assign run_s = en && (state_r == LOCKED);

    lock_err_window #(
        .WIN         (WIN),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) u_err_window (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_s),
        .err   (err_s),
        .trip  (trip_s)
    );

    // Next-state logic, quiet-run counter and lock/LOL events.
    always_comb begin
        state_nxt_s = IDLE;
        qcnt_nxt_s  = '0;
        lock_evt_s  = 1'b0;
        lol_evt_s   = 1'b0;
        if (!en) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = ACQ;
                end
                ACQ: begin
                    if (err_s) begin
                        state_nxt_s = ACQ;
                        qcnt_nxt_s  = '0;
                    end else if (qcnt_r == QCNT_LAST) begin
                        // This quiet cycle completes the run: lock now.
                        state_nxt_s = LOCKED;
                        lock_evt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ACQ;
                        qcnt_nxt_s  = qcnt_r + QCNT_ONE;
                    end
                end
                LOCKED: begin
                    if (trip_s) begin
                        state_nxt_s = ACQ;
                        lol_evt_s   = 1'b1;
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Saturating acquisition counter and sticky flag (set beats clear).
    always_comb begin
        lock_cnt_nxt_s   = lock_cnt_r;
        lol_sticky_nxt_s = lol_sticky_r;
        if (lock_evt_s && (lock_cnt_r != LCNT_MAX)) begin
            lock_cnt_nxt_s = lock_cnt_r + LCNT_ONE;
        end else begin
            lock_cnt_nxt_s = lock_cnt_r;
        end
        if (lol_evt_s) begin
            lol_sticky_nxt_s = 1'b1;
        end else if (clr_sticky) begin
            lol_sticky_nxt_s = 1'b0;
        end else begin
            lol_sticky_nxt_s = lol_sticky_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            qcnt_r       <= '0;
            lock_cnt_r   <= '0;
            locked_r     <= 1'b0;
            lol_pulse_r  <= 1'b0;
            lol_sticky_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            qcnt_r       <= qcnt_nxt_s;
            lock_cnt_r   <= lock_cnt_nxt_s;
            locked_r     <= (state_nxt_s == LOCKED);
            lol_pulse_r  <= lol_evt_s;
            lol_sticky_r <= lol_sticky_nxt_s;
        end
    end

    assign locked     = locked_r;
    assign state      = state_r;
    assign lol_pulse  = lol_pulse_r;
    assign lol_sticky = lol_sticky_r;
    assign lock_cnt   = lock_cnt_r;

endmodule

// File: tb/tb_lock_monitor.sv
// Bench for lock_monitor. Two instances share every input: one treats
// up&&dn as quiet, the other as an error. A cycle-level reference model
// produces the expected outputs after each edge and queues them; a separate
// monitor pops and compares after every clock edge.
module tb_lock_monitor;

    localparam int LOCK_CNT    = 8;
    localparam int WIN         = 16;
    localparam int UNLOCK_ERRS = 3;
    localparam int CNT_W       = 2;

    localparam int M_IDLE   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n      = 1'b0;
    logic en         = 1'b0;
    logic up         = 1'b0;
    logic dn         = 1'b0;
    logic clr_sticky = 1'b0;

    logic [1:0]       locked_v;
    logic [1:0]       pulse_v;
    logic [1:0]       sticky_v;
    logic [1:0]       state_v [2];
    logic [CNT_W-1:0] lcnt_v  [2];

    lock_monitor #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERRS(UNLOCK_ERRS),
                   .BOTH_IS_QUIET(1), .CNT_W(CNT_W)) dut_q (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .clr_sticky(clr_sticky),
        .locked(locked_v[0]), .state(state_v[0]), .lol_pulse(pulse_v[0]),
        .lol_sticky(sticky_v[0]), .lock_cnt(lcnt_v[0]));

    lock_monitor #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERRS(UNLOCK_ERRS),
                   .BOTH_IS_QUIET(0), .CNT_W(CNT_W)) dut_e (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .clr_sticky(clr_sticky),
        .locked(locked_v[1]), .state(state_v[1]), .lol_pulse(pulse_v[1]),
        .lol_sticky(sticky_v[1]), .lock_cnt(lcnt_v[1]));

    typedef struct packed {
        logic             locked;
        logic [1:0]       st;
        logic             pulse;
        logic             sticky;
        logic [CNT_W-1:0] lcnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cycle  = 0;

    // Reference model state, one set per instance.
    int m_st[2], m_run[2], m_wpos[2], m_werr[2], m_lcnt[2];
    bit m_locked[2], m_pulse[2], m_sticky[2];

    task automatic chk(input string name, input int v, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, v, cycle, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Behavioural model: quiet run length, position/errors in the window.
    task automatic model_step(input int b, input bit r, input bit e, input bit u, input bit d, input bit c);
        bit err;
        bit lol;
        lol = 1'b0;
        if (!r) begin
            m_st[b] = M_IDLE; m_run[b] = 0; m_wpos[b] = 0; m_werr[b] = 0; m_lcnt[b] = 0;
            m_locked[b] = 0; m_pulse[b] = 0; m_sticky[b] = 0;
            return;
        end
        err = (b == 0) ? (u != d) : (u || d);
        if (!e) begin
            m_st[b] = M_IDLE; m_run[b] = 0; m_wpos[b] = 0; m_werr[b] = 0; m_locked[b] = 0;
        end else if (m_st[b] == M_IDLE) begin
            m_st[b] = M_ACQ;
        end else if (m_st[b] == M_ACQ) begin
            m_run[b] = err ? 0 : m_run[b] + 1;
            if (m_run[b] == LOCK_CNT) begin
                m_st[b] = M_LOCKED; m_locked[b] = 1; m_run[b] = 0;
                m_wpos[b] = 0; m_werr[b] = 0;
                if (m_lcnt[b] < (1 << CNT_W) - 1) m_lcnt[b]++;
            end
        end else begin
            m_werr[b] += err ? 1 : 0;
            if (m_werr[b] == UNLOCK_ERRS) begin
                lol = 1; m_st[b] = M_ACQ; m_locked[b] = 0; m_run[b] = 0;
                m_wpos[b] = 0; m_werr[b] = 0;
            end else begin
                m_wpos[b]++;
                if (m_wpos[b] == WIN) begin
                    m_wpos[b] = 0; m_werr[b] = 0;
                end
            end
        end
        m_pulse[b] = lol;
        if (lol) m_sticky[b] = 1;
        else if (c) m_sticky[b] = 0;
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic cyc(input bit r, input bit e, input bit u, input bit d, input bit c);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; up = u; dn = d; clr_sticky = c;
        for (int b = 0; b < 2; b++) begin
            model_step(b, r, e, u, d, c);
            x.locked = m_locked[b];
            x.st     = 2'(m_st[b]);
            x.pulse  = m_pulse[b];
            x.sticky = m_sticky[b];
            x.lcnt   = CNT_W'(m_lcnt[b]);
            exp_q.push_back(x);
        end
    endtask

    // Monitor: compare DUT outputs with queued expectations after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            cycle++;
            if (exp_q.size() >= 2) begin
                for (int v = 0; v < 2; v++) begin
                    x = exp_q.pop_front();
                    chk("locked", v, 8'(locked_v[v]), 8'(x.locked));
                    chk("state", v, 8'(state_v[v]), 8'(x.st));
                    chk("lol_pulse", v, 8'(pulse_v[v]), 8'(x.pulse));
                    chk("lol_sticky", v, 8'(sticky_v[v]), 8'(x.sticky));
                    chk("lock_cnt", v, 8'(lcnt_v[v]), 8'(x.lcnt));
                end
            end
        end
    end

    initial begin
        int noise;
        // Reset
        repeat (3) cyc(0, 0, 0, 0, 0);
        // Plain acquisition
        repeat (12) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Error on quiet cycle 7 restarts the run
        cyc(1, 1, 0, 0, 0);
        repeat (6) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        repeat (10) cyc(1, 1, 0, 0, 0);
        // Two errors per window stay locked
        repeat (2) begin
            cyc(1, 1, 1, 0, 0);
            cyc(1, 1, 0, 1, 0);
            repeat (14) cyc(1, 1, 0, 0, 0);
        end
        // up&&dn every cycle
        cyc(1, 0, 0, 0, 0);
        repeat (14) cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0);
        // Lock/LOL loops with clr_sticky coincident then alone
        repeat (6) begin
            repeat (10) cyc(1, 1, 0, 0, 0);
            cyc(1, 1, 0, 1, 0);
            cyc(1, 1, 1, 0, 0);
            cyc(1, 1, 0, 1, 1);
            cyc(1, 1, 0, 0, 1);
        end
        // LOL leaving sticky set, then en=0 while locked
        repeat (10) cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(1, 1, 1, 0, 0);
        repeat (10) cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        // Reset in the middle of acquisition
        repeat (4) cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        // Randomised traffic with varying noise levels
        noise = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 24 == 0) begin
                case ($urandom_range(0, 3))
                    0: noise = 0;
                    1: noise = 2;
                    2: noise = 10;
                    default: noise = 40;
                endcase
            end
            cyc(($urandom_range(0, 499) != 0),
                ($urandom_range(0, 99) != 0),
                ($urandom_range(0, 99) < noise),
                ($urandom_range(0, 99) < noise),
                ($urandom_range(0, 9) == 0));
        end
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 0, 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
